// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous Rx line plus falling-edge detect.
module uart_rx_sync (
    input  logic baud_clock,
    input  logic reset,
    input  logic Rx,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_meta;
    logic rx_prev;

    // Flops reset to the idle (high) line level so reset never fakes a start.
    always_ff @(posedge baud_clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with parity/framing/overrun flags and a valid/ready holding register.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 baud_clock,
    input  logic                 reset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 data_rdy,
    input  logic                 data_ack,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = OVERSAMPLE / 2;
`else
    localparam int START_DEC = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [CW-1:0] START_LAST = CW'(START_DEC);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

    uart_rx_state_e         state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_err_f, frame_err_f, done_q;
    logic                   cnt_clr, shift_en, par_en, stop_en, frame_done;
    logic                   rx_s, rx_fall, bit_val;

    uart_rx_sync u_sync (
        .baud_clock (baud_clock),
        .reset      (reset),
        .Rx         (Rx),
        .rx_s       (rx_s),
        .rx_fall    (rx_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous samples; with the current one they form the mid-1/mid/mid+1 vote.
    logic [1:0] hist;
    always_ff @(posedge baud_clock) begin
        if (reset) hist <= 2'b11;
        else       hist <= {hist[0], rx_s};
    end
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge baud_clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (rx_fall) begin
                state_nxt = START;
                cnt_clr   = 1'b1;
            end
            // A high mid-bit sample means a glitch, not a start bit.
            START: if (cnt == START_LAST) begin
                cnt_clr   = 1'b1;
                state_nxt = bit_val ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_LAST) begin
                shift_en = 1'b1;
                if (bit_cnt == DATA_LAST)
                    state_nxt = (PARITY == PARITY_NONE) ? STOP : uart_pkg::PARITY;
            end
            uart_pkg::PARITY: if (cnt == BIT_LAST) begin
                par_en    = 1'b1;
                state_nxt = STOP;
            end
            STOP: if (cnt == BIT_LAST) begin
                stop_en = 1'b1;
                if (bit_cnt == STOP_LAST) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample counter free-runs modulo OVERSAMPLE outside IDLE; bit counter serves data and stop bits.
    always_ff @(posedge baud_clock) begin
        if (reset) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_err_f   <= 1'b0;
            frame_err_f <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= frame_done;
            if (cnt_clr || state == IDLE) cnt <= '0;
            else if (cnt == BIT_LAST)     cnt <= '0;
            else                          cnt <= cnt + 1'b1;

            if (state == IDLE)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
            else if (stop_en)
                bit_cnt <= bit_cnt + 1'b1;

            if (state == IDLE && rx_fall) begin
                par_err_f   <= 1'b0;
                frame_err_f <= 1'b0;
            end
            if (shift_en) shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            if (par_en)   par_err_f <= ((^shift_reg) ^ bit_val) != (PARITY == PARITY_ODD);
            if (stop_en && !bit_val) frame_err_f <= 1'b1;
        end
    end

    // Holding register: accept a finished frame if empty or being drained this cycle, else flag overrun.
    always_ff @(posedge baud_clock) begin
        if (reset) begin
            data_received <= '0;
            data_rdy      <= 1'b0;
            parity_err    <= 1'b0;
            framing_err   <= 1'b0;
            overrun_err   <= 1'b0;
        end else if (done_q) begin
            if (!data_rdy || data_ack) begin
                data_received <= shift_reg;
                data_rdy      <= 1'b1;
                parity_err    <= (PARITY != PARITY_NONE) && par_err_f;
                framing_err   <= frame_err_f;
            end else begin
                overrun_err   <= 1'b1;
            end
        end else if (data_rdy && data_ack) begin
            data_received <= '0;
            data_rdy      <= 1'b0;
            parity_err    <= 1'b0;
            framing_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed self-checking bench: an 8N1 instance and an 8E1 instance driven with hand-built frames.
`timescale 1ns/1ps
module tb_uart_rx_framed;
    import uart_pkg::*;

    logic       baud_clock = 1'b0;
    logic       reset;
    logic       rx0, rx1, ack0, ack1;
    logic [7:0] data_received0, data_received1;
    logic       data_rdy0, data_rdy1;
    logic       parity_err0, parity_err1, framing_err0, framing_err1, overrun_err0, overrun_err1;

    int checks = 0;
    int errors = 0;
    int rdy_count0 = 0;

`ifdef UART_RX_MAJORITY_EN
    localparam int LAT0 = 156;
    localparam int LAT1 = 172;
    localparam int SPIKE = 72;
`else
    localparam int LAT0 = 155;
    localparam int LAT1 = 171;
    localparam int SPIKE = -1;
`endif

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
        .baud_clock(baud_clock), .reset(reset), .Rx(rx0),
        .data_received(data_received0), .data_rdy(data_rdy0), .data_ack(ack0),
        .parity_err(parity_err0), .framing_err(framing_err0), .overrun_err(overrun_err0)
    );

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut1 (
        .baud_clock(baud_clock), .reset(reset), .Rx(rx1),
        .data_received(data_received1), .data_rdy(data_rdy1), .data_ack(ack1),
        .parity_err(parity_err1), .framing_err(framing_err1), .overrun_err(overrun_err1)
    );

    always #5 baud_clock = ~baud_clock;

    always @(negedge baud_clock) if (data_rdy0) rdy_count0 = rdy_count0 + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] outs(input int sel);
        if (sel == 0) return 32'({data_received0, data_rdy0, parity_err0, framing_err0, overrun_err0});
        return 32'({data_received1, data_rdy1, parity_err1, framing_err1, overrun_err1});
    endfunction

    // Drives one frame (or its first nbits bits) starting right after a negedge, 16 cycles per bit.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic par_bit,
                                 input logic stop_val, input int spike_at, input int nbits);
        logic [11:0] bits;
        logic        v;
        int          n;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (sel == 1) begin
            bits[9]  = par_bit;
            bits[10] = stop_val;
            n = 11;
        end else begin
            bits[9] = stop_val;
            n = 10;
        end
        if (nbits > 0 && nbits < n) n = nbits;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 16; j++) begin
                v = bits[i] ^ ((i * 16 + j) == spike_at);
                if (sel == 1) rx1 = v;
                else          rx0 = v;
                @(negedge baud_clock);
            end
        end
    endtask

    // Latency counted from the first edge that samples Rx low; also captures payload, flags and next-cycle data_rdy.
    task automatic measureFrame(input int sel, input int limit, output int lat, output logic [7:0] data,
                                output logic [2:0] flags, output logic rdy_next);
        logic [31:0] o;
        lat = -1; data = '0; flags = '0; rdy_next = 1'b1;
        @(posedge baud_clock);
        for (int c = 0; c < limit && lat < 0; c++) begin
            @(negedge baud_clock);
            o = outs(sel);
            if (o[3]) begin
                lat   = c;
                data  = o[11:4];
                flags = o[2:0];
                @(negedge baud_clock);
                o = outs(sel);
                rdy_next = o[3];
            end
        end
    endtask

    int          lat, base;
    logic [7:0]  got;
    logic [2:0]  flags;
    logic        rdy_next;
    logic [7:0]  vec [3] = '{8'h55, 8'h96, 8'h01};

    initial begin
        reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ack0 = 1'b1; ack1 = 1'b1;
        repeat (4) @(negedge baud_clock);
        checkOutput("reset_outs0", outs(0), 32'h0);
        checkOutput("reset_outs1", outs(1), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge baud_clock);

        for (int i = 0; i < 3; i++) begin
            fork
                applyStimulus(0, vec[i], 1'b0, 1'b1, (i == 0) ? SPIKE : -1, 0);
                measureFrame(0, 400, lat, got, flags, rdy_next);
            join
            checkOutput("8n1_latency", 32'(lat), 32'(LAT0));
            checkOutput("8n1_data", 32'(got), 32'(vec[i]));
            checkOutput("8n1_flags", 32'(flags), 32'h0);
            checkOutput("8n1_rdy_one_cycle", 32'(rdy_next), 32'h0);
            repeat (10) @(negedge baud_clock);
        end

        base = rdy_count0;
        rx0 = 1'b0;
        repeat (6) @(negedge baud_clock);
        rx0 = 1'b1;
        repeat (40) @(negedge baud_clock);
        checkOutput("glitch_no_rdy", 32'(rdy_count0 - base), 32'h0);
        checkOutput("glitch_outs", outs(0), 32'h0);
        checkOutput("glitch_state", 32'(dut0.state), 32'(IDLE));

        fork
            applyStimulus(1, 8'hA3, 1'b1, 1'b1, -1, 0);
            measureFrame(1, 400, lat, got, flags, rdy_next);
        join
        checkOutput("par_bad_latency", 32'(lat), 32'(LAT1));
        checkOutput("par_bad_data", 32'(got), 32'hA3);
        checkOutput("par_bad_flags", 32'(flags), 32'b100);
        repeat (10) @(negedge baud_clock);
        fork
            applyStimulus(1, 8'hA3, 1'b0, 1'b1, -1, 0);
            measureFrame(1, 400, lat, got, flags, rdy_next);
        join
        checkOutput("par_ok_data", 32'(got), 32'hA3);
        checkOutput("par_ok_flags", 32'(flags), 32'b000);
        repeat (10) @(negedge baud_clock);

        base = rdy_count0;
        fork
            applyStimulus(0, 8'h0F, 1'b0, 1'b0, -1, 0);
            measureFrame(0, 400, lat, got, flags, rdy_next);
        join
        checkOutput("frm_data", 32'(got), 32'h0F);
        checkOutput("frm_flags", 32'(flags), 32'b010);
        repeat (400) @(negedge baud_clock);
        checkOutput("break_single_frame", 32'(rdy_count0 - base), 32'h1);
        rx0 = 1'b1;
        repeat (40) @(negedge baud_clock);
        fork
            applyStimulus(0, 8'h5A, 1'b0, 1'b1, -1, 0);
            measureFrame(0, 400, lat, got, flags, rdy_next);
        join
        checkOutput("after_break_data", 32'(got), 32'h5A);
        checkOutput("after_break_flags", 32'(flags), 32'h0);
        repeat (10) @(negedge baud_clock);

        ack0 = 1'b0;
        fork
            applyStimulus(0, 8'h11, 1'b0, 1'b1, -1, 0);
            measureFrame(0, 400, lat, got, flags, rdy_next);
        join
        checkOutput("ovr_first_data", 32'(got), 32'h11);
        checkOutput("ovr_first_flags", 32'(flags), 32'h0);
        repeat (5) @(negedge baud_clock);
        applyStimulus(0, 8'h22, 1'b0, 1'b1, -1, 0);
        repeat (5) @(negedge baud_clock);
        checkOutput("ovr_held_outs", outs(0), 32'({8'h11, 1'b1, 1'b0, 1'b0, 1'b1}));
        ack0 = 1'b1;
        @(negedge baud_clock);
        ack0 = 1'b0;
        checkOutput("ovr_after_ack_outs", outs(0), 32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
        repeat (5) @(negedge baud_clock);
        checkOutput("ovr_sticky", 32'(overrun_err0), 32'h1);

        ack0 = 1'b1;
        base = rdy_count0;
        applyStimulus(0, 8'h3C, 1'b0, 1'b1, -1, 5);
        reset = 1'b1;
        rx0 = 1'b1;
        repeat (2) @(negedge baud_clock);
        checkOutput("midframe_reset_outs", outs(0), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge baud_clock);
        fork
            applyStimulus(0, 8'h7E, 1'b0, 1'b1, -1, 0);
            measureFrame(0, 400, lat, got, flags, rdy_next);
        join
        checkOutput("post_reset_latency", 32'(lat), 32'(LAT0));
        checkOutput("post_reset_data", 32'(got), 32'h7E);
        checkOutput("post_reset_flags", 32'(flags), 32'h0);
        repeat (5) @(negedge baud_clock);
        checkOutput("post_reset_only_one", 32'(rdy_count0 - base), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
